wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the core's register file: it collects completed results from the ALU and load/store unit over valid/ready handshakes and buffers each source in a small FIFO. It drains one result per cycle onto the register file write port (`rd`, `WriteData`, `reg_write`), which the register file commits on the falling clock edge. It also exports a pending-write mask that the issue stage uses for hazard stalls.

## Interface
- `XLEN`, 64: datapath width.
- `DEPTH`, 2: entries per source FIFO; power of two, ≥ 2.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU FIFO can accept.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `lsu_valid`  in  1  load result present.
- `lsu_ready`  out  1  LSU FIFO can accept.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  XLEN  load result.
- `rd`  out  5  register file write index.
- `WriteData`  out  XLEN  register file write data.
- `reg_write`  out  1  register file write enable.
- `busy_mask`  out  32  bit i = 1 means a write to xi is pending.

## Operation
- **Accept.** A source transfer occurs on a rising edge when valid && ready. The entry {rd, data} is pushed into that source's FIFO.
- **Ready.** `x_ready` = !full && !reset. It depends only on occupancy and never on the same-cycle pop, so there is no full-FIFO bypass.
- **Grant.** Each cycle at most one FIFO is popped.
  - Only one FIFO non-empty: pop that one.
  - Both non-empty: round-robin. Pop the source not granted last.
  - The last-grant pointer resets to "ALU", so LSU wins the first tie.
- **Output register.** On a pop, `rd`, `WriteData` and `reg_write` = 1 are loaded. With no pop, `reg_write` = 0 and `rd`/`WriteData` hold their previous values.
- **x0 handling.** An entry with rd = 0 is accepted and popped normally, but it produces `reg_write` = 0. Such entries never set `busy_mask`.
- **busy_mask** (combinational from state) = OR of onehot(rd) over:
  - all valid entries in both FIFOs, and
  - the output register while `reg_write` = 1.
  - Bit 0 is always 0.
- **Ordering.** Within a source, writes retire in FIFO order. Across sources, no ordering is guaranteed. The issue stage must not issue an instruction whose rd is set in `busy_mask`. The bench checks this as an assertion: no two live entries share a non-zero rd.

## Timing
- **Reset values.** While `reset` is asserted:
  - FIFOs empty, counts 0, grant pointer = ALU.
  - `reg_write` = 0, `rd` = 0, `WriteData` = 0, `busy_mask` = 0.
  - `alu_ready` = `lsu_ready` = 0.
  - Ready rises in the first cycle after deassertion.
- **Latency.** Accept at edge N, pop at edge N+1 at the earliest, `reg_write` high during cycle N+1. The register file commits at that cycle's falling edge. Minimum accept-to-commit is one cycle.
- **Throughput.** One write per cycle. Both sources continuously valid → each sustains 1/2 rate without starvation.
- **Simultaneous push and pop** on one FIFO: count unchanged. Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- **Full FIFO with valid held high:** the source stalls. The entry is accepted on the first edge after ready rises.
- **Reset mid-operation:** all buffered entries are discarded and none are written.

## Structure
- Package `wb_pkg`:
  - `XLEN` default, `NREGS` = 32.
  - `wb_entry_t` struct {logic [4:0] rd; logic [XLEN-1:0] data}.
  - `wb_src_e` enum {WB_SRC_ALU, WB_SRC_LSU} for the grant pointer.
- Sub-module `wb_fifo`: parameterised DEPTH-entry synchronous FIFO of `wb_entry_t`. It exposes push, pop, full, empty, head and per-entry valid/rd for busy_mask. It is instantiated once per source.
- The top level holds the arbiter, the output register and the mask logic.

## Test plan
- **Reset release.** Assert reset mid-traffic with 2 entries buffered → no `reg_write`; `busy_mask` = 0; ready = 0 during reset and 1 on the cycle after release.
- **Single ALU write.** alu rd = 5, data = 0xDEAD at edge N → `reg_write` = 1, `rd` = 5, `WriteData` = 0xDEAD in cycle N+1. `busy_mask` bit 5 is set from after edge N through cycle N+1 and cleared after.
- **Tie arbitration.** Both FIFOs hold 2 entries (ALU rd 1, 2; LSU rd 3, 4) → write order 3, 1, 4, 2 on consecutive cycles.
- **Backpressure.** Hold lsu_valid for DEPTH+2 cycles while ALU floods → `lsu_ready` drops when the LSU FIFO is full; no entry is lost or duplicated; output order matches push order per source.
- **x0 discard.** alu rd = 0, data = 0x1234 → accepted and popped; `reg_write` stays 0; `busy_mask` stays 0.
- **Push/pop same cycle.** With the FIFO at count 1, push and pop on the same edge → count stays 1; head advances correctly across pointer wrap.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types and constants for the register-file writeback arbiter.
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : Source handshakes, register-file write port and hazard mask.
// Revision : 1.0
// ============================================================================
interface wb_arbiter_if;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [4:0]               alu_rd;
    logic [wb_pkg::XLEN-1:0]  alu_data;
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [4:0]               lsu_rd;
    logic [wb_pkg::XLEN-1:0]  lsu_data;
    logic [4:0]               rd;
    logic [wb_pkg::XLEN-1:0]  WriteData;
    logic                     reg_write;
    logic [wb_pkg::NREGS-1:0] busy_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, rd, WriteData, reg_write, busy_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, rd, WriteData, reg_write, busy_mask
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : DEPTH-entry synchronous FIFO of writeback entries with per-slot view.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  push,
    input  wire wb_entry_t             push_entry,
    input  wire logic                  pop,
    output logic                       full,
    output logic                       empty,
    output wb_entry_t                  head,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [DEPTH-1:0][4:0]      entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         w_offset;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_offset    = '0;
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset       = PW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, w_offset} < count_q);
            entry_rd[i]    = mem_q[i].rd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Round-robin writeback arbiter (ALU/LSU) with registered RF write port.
// Revision : 1.0
// ============================================================================
module wb_arbiter
    import wb_pkg::wb_entry_t, wb_pkg::wb_src_e, wb_pkg::WB_SRC_ALU,
           wb_pkg::WB_SRC_LSU, wb_pkg::NREGS;
#(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    wb_arbiter_if.slave bus
);

    wb_entry_t               w_alu_entry, w_lsu_entry;
    wb_entry_t               w_alu_head, w_lsu_head;
    logic                    w_alu_full, w_alu_empty, w_lsu_full, w_lsu_empty;
    logic                    w_alu_push, w_lsu_push, w_alu_pop, w_lsu_pop;
    logic [DEPTH-1:0]        w_alu_vld, w_lsu_vld;
    logic [DEPTH-1:0][4:0]   w_alu_rds, w_lsu_rds;
    logic [NREGS-1:0]        w_busy;

    wb_src_e                 last_grant_q, last_grant_d;
    logic                    reg_write_q, reg_write_d;
    logic [4:0]              rd_q, rd_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;

    assign bus.alu_ready = !w_alu_full && !reset;
    assign bus.lsu_ready = !w_lsu_full && !reset;
    assign w_alu_push    = bus.alu_valid && bus.alu_ready;
    assign w_lsu_push    = bus.lsu_valid && bus.lsu_ready;

    always_comb begin
        w_alu_entry.rd   = bus.alu_rd;
        w_alu_entry.data = bus.alu_data;
        w_lsu_entry.rd   = bus.lsu_rd;
        w_lsu_entry.data = bus.lsu_data;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_alu_push),
        .push_entry (w_alu_entry),
        .pop        (w_alu_pop),
        .full       (w_alu_full),
        .empty      (w_alu_empty),
        .head       (w_alu_head),
        .entry_valid(w_alu_vld),
        .entry_rd   (w_alu_rds)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_lsu_push),
        .push_entry (w_lsu_entry),
        .pop        (w_lsu_pop),
        .full       (w_lsu_full),
        .empty      (w_lsu_empty),
        .head       (w_lsu_head),
        .entry_valid(w_lsu_vld),
        .entry_rd   (w_lsu_rds)
    );

    // On a tie the source that was not granted last wins.
    always_comb begin
        w_alu_pop = 1'b0;
        w_lsu_pop = 1'b0;
        if (!w_alu_empty && !w_lsu_empty) begin
            if (last_grant_q == WB_SRC_ALU) w_lsu_pop = 1'b1;
            else                            w_alu_pop = 1'b1;
        end else if (!w_alu_empty) begin
            w_alu_pop = 1'b1;
        end else if (!w_lsu_empty) begin
            w_lsu_pop = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        if (w_alu_pop) begin
            last_grant_d = WB_SRC_ALU;
            rd_d         = w_alu_head.rd;
            wdata_d      = w_alu_head.data;
            reg_write_d  = |w_alu_head.rd;
        end else if (w_lsu_pop) begin
            last_grant_d = WB_SRC_LSU;
            rd_d         = w_lsu_head.rd;
            wdata_d      = w_lsu_head.data;
            reg_write_d  = |w_lsu_head.rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= WB_SRC_ALU;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    // x0 entries may sit in the FIFOs; bit 0 is cleared last so they never show.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_vld[i]) w_busy[w_alu_rds[i]] = 1'b1;
            if (w_lsu_vld[i]) w_busy[w_lsu_rds[i]] = 1'b1;
        end
        if (reg_write_q) w_busy[rd_q] = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign bus.busy_mask = w_busy;
    assign bus.reg_write = reg_write_q;
    assign bus.rd        = rd_q;
    assign bus.WriteData = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed vector table plus backpressure and reset sequences.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    wb_arbiter_if bus ();

    wb_arbiter #(.XLEN(64), .DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ldat;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_rw;
        logic        chk_rd;
        logic [4:0]  e_rd;
        logic [63:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [63:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                                input logic ear, input logic elr, input logic erw,
                                input logic crd, input logic [4:0] erd, input logic [63:0] ewd,
                                input logic [31:0] eb);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_ardy = ear; v.e_lrdy = elr; v.e_rw = erw;
        v.chk_rd = crd; v.e_rd = erd; v.e_wd = ewd; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [4:0]  aq_rd[$], lq_rd[$];
    logic [63:0] aq_d[$],  lq_d[$];

    initial begin : main
        int          a_idx, l_idx;
        logic        a_acc, l_acc, saw_stall, exp_pop;
        logic [4:0]  prd;
        logic [63:0] pd;
        logic [31:0] eb;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive_idle();

        vecs[0]  = mk(1, 5, 'hDEAD, 0, 0, 0,     1, 1, 0, 1, 0, 0,      'h20);
        vecs[1]  = mk(0, 0, 0,      0, 0, 0,     1, 1, 1, 1, 5, 'hDEAD, 'h20);
        vecs[2]  = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 1, 5, 'hDEAD, 'h0);
        vecs[3]  = mk(1, 1, 'h11,   1, 3, 'h33,  1, 1, 0, 1, 5, 'hDEAD, 'h0A);
        vecs[4]  = mk(1, 2, 'h22,   1, 4, 'h44,  1, 1, 1, 1, 3, 'h33,   'h1E);
        vecs[5]  = mk(0, 0, 0,      0, 0, 0,     0, 1, 1, 1, 1, 'h11,   'h16);
        vecs[6]  = mk(0, 0, 0,      0, 0, 0,     1, 1, 1, 1, 4, 'h44,   'h14);
        vecs[7]  = mk(0, 0, 0,      0, 0, 0,     1, 1, 1, 1, 2, 'h22,   'h04);
        vecs[8]  = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 1, 2, 'h22,   'h0);
        vecs[9]  = mk(1, 0, 'h1234, 0, 0, 0,     1, 1, 0, 1, 2, 'h22,   'h0);
        vecs[10] = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 0, 0, 0,      'h0);
        vecs[11] = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 0, 0, 0,      'h0);
        vecs[12] = mk(1, 6, 'h66,   0, 0, 0,     1, 1, 0, 0, 0, 0,      'h40);
        vecs[13] = mk(1, 7, 'h77,   0, 0, 0,     1, 1, 1, 1, 6, 'h66,   'hC0);
        vecs[14] = mk(1, 8, 'h88,   0, 0, 0,     1, 1, 1, 1, 7, 'h77,   'h180);
        vecs[15] = mk(0, 0, 0,      0, 0, 0,     1, 1, 1, 1, 8, 'h88,   'h100);
        vecs[16] = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 1, 8, 'h88,   'h0);
        vecs[17] = mk(0, 0, 0,      1, 9, 'h99,  1, 1, 0, 1, 8, 'h88,   'h200);
        vecs[18] = mk(0, 0, 0,      0, 0, 0,     1, 1, 1, 1, 9, 'h99,   'h200);
        vecs[19] = mk(0, 0, 0,      0, 0, 0,     1, 1, 0, 1, 9, 'h99,   'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_rd",        bus.rd, 0);
        chk("rst_wdata",     bus.WriteData, 0);
        chk("rst_busy",      bus.busy_mask, 0);
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_lsu_ready", bus.lsu_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_alu_ready", bus.alu_ready, 1);
        chk("rel_lsu_ready", bus.lsu_ready, 1);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.alu_valid = vecs[i].av; bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].adat;
            bus.lsu_valid = vecs[i].lv; bus.lsu_rd = vecs[i].lrd; bus.lsu_data = vecs[i].ldat;
            #1;
            chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, vecs[i].e_ardy);
            chk($sformatf("v%0d_lsu_ready", i), bus.lsu_ready, vecs[i].e_lrdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reg_write", i), bus.reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d_busy", i), bus.busy_mask, vecs[i].e_busy);
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_rd", i), bus.rd, vecs[i].e_rd);
                chk($sformatf("v%0d_wdata", i), bus.WriteData, vecs[i].e_wd);
            end
        end

        // Backpressure: ALU floods, LSU valid held for DEPTH+2 cycles
        a_idx = 0; l_idx = 0; saw_stall = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bus.alu_valid = (a_idx < 10);
            bus.alu_rd    = 5'(10 + a_idx);
            bus.alu_data  = 64'hA000 + 64'(a_idx);
            bus.lsu_valid = (cyc < 4);
            bus.lsu_rd    = 5'(20 + l_idx);
            bus.lsu_data  = 64'hB000 + 64'(l_idx);
            #1;
            a_acc = bus.alu_valid && bus.alu_ready;
            l_acc = bus.lsu_valid && bus.lsu_ready;
            if (bus.lsu_valid && !bus.lsu_ready) saw_stall = 1'b1;
            exp_pop = (aq_rd.size() + lq_rd.size()) > 0;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_reg_write", cyc), bus.reg_write, exp_pop);
            eb = '0;
            if (bus.reg_write) begin
                if (bus.rd >= 20 && lq_rd.size() > 0) begin
                    prd = lq_rd.pop_front(); pd = lq_d.pop_front();
                end else if (bus.rd < 20 && aq_rd.size() > 0) begin
                    prd = aq_rd.pop_front(); pd = aq_d.pop_front();
                end else begin
                    prd = '0; pd = '0;
                    tests++; fails++;
                    $display("FAIL bp%0d_unexpected: got rd %0d, expected no write", cyc, bus.rd);
                end
                chk($sformatf("bp%0d_rd", cyc), bus.rd, prd);
                chk($sformatf("bp%0d_wdata", cyc), bus.WriteData, pd);
                eb[prd] = 1'b1;
            end
            if (a_acc) begin aq_rd.push_back(bus.alu_rd); aq_d.push_back(bus.alu_data); a_idx++; end
            if (l_acc) begin lq_rd.push_back(bus.lsu_rd); lq_d.push_back(bus.lsu_data); l_idx++; end
            foreach (aq_rd[k]) eb[aq_rd[k]] = 1'b1;
            foreach (lq_rd[k]) eb[lq_rd[k]] = 1'b1;
            chk($sformatf("bp%0d_busy", cyc), bus.busy_mask, eb);
        end
        drive_idle();
        chk("bp_lsu_ready_dropped", saw_stall, 1);
        chk("bp_alu_all_accepted", a_idx, 10);
        chk("bp_alu_drained", aq_rd.size(), 0);
        chk("bp_lsu_drained", lq_rd.size(), 0);

        // Reset mid-operation with two entries buffered
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd25; bus.alu_data = 64'hC1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd26; bus.lsu_data = 64'hC2;
        @(posedge clk);
        #1;
        chk("mid_busy_before", bus.busy_mask, 32'h0600_0000);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("mid_busy_rst",      bus.busy_mask, 0);
        chk("mid_reg_write_rst", bus.reg_write, 0);
        chk("mid_rd_rst",        bus.rd, 0);
        chk("mid_wdata_rst",     bus.WriteData, 0);
        chk("mid_alu_ready_rst", bus.alu_ready, 0);
        chk("mid_lsu_ready_rst", bus.lsu_ready, 0);
        @(posedge clk);
        #1;
        chk("mid_reg_write_hold", bus.reg_write, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_alu_ready_rel", bus.alu_ready, 1);
        chk("mid_lsu_ready_rel", bus.lsu_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_post%0d_reg_write", c), bus.reg_write, 0);
            chk($sformatf("mid_post%0d_busy", c), bus.busy_mask, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
